i2c_master_burst: RTL and testbench

Parametrised I2C master for single-master buses. Performs register-addressed write bursts and read bursts with repeated START, and supports 1–2 register-address bytes. Uses open-drain pin control, ACK/NACK detection and SCL clock stretching. Sits between a local register/DMA client and the board-level I2C pads.

---
 rtl/i2c_master_burst.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_burst.sv
// Single-master I2C burst engine: register-addressed write and read bursts
// over open-drain SDA/SCL, with ACK/NACK detection and SCL stretching.
module i2c_master_burst #(
    parameter int CLK_DIV        = 4,
    parameter int REG_ADDR_BYTES = 1,
    parameter int MAX_BURST      = 16
) (
    input  logic                           dclk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           rw,
    input  logic [6:0]                     slv_addr,
    input  logic [8*REG_ADDR_BYTES-1:0]    reg_addr,
    input  logic [$clog2(MAX_BURST+1)-1:0] byte_cnt,
    input  logic [7:0]                     wr_data,
    output logic                           wr_req,
    output logic [7:0]                     rd_data,
    output logic                           rd_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           nack,
    input  logic                           sda_i,
    output logic                           sda_oe,
    input  logic                           scl_i,
    output logic                           scl_oe
);

    localparam int CW = $clog2(MAX_BURST+1);
    localparam int RW = 8*REG_ADDR_BYTES;
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_REG, S_WDATA,
        S_RSTART, S_RADDR, S_RDATA, S_STOP
    } state_t;

    state_t        state;
    logic [1:0]    q;
    logic [QW-1:0] qc;
    logic [3:0]    bitn;
    logic [7:0]    sh;
    logic [7:0]    wbuf;
    logic [RW-1:0] reg_q;
    logic [0:0]    ridx;
    logic [CW-1:0] left;
    logic          rw_q;
    logic [6:0]    slv_q;
    logic          ack_bad;
    logic          nack_hit;

    logic hold, qend, slot_end, sample;
    logic is_tx, last_reg, prefetch;
    logic sda_nx, scl_nx;

    // A stretching slave freezes the quarter counter while SCL is released in q2
    assign hold     = (q == 2'd2) && !scl_oe && !scl_i;
    assign qend     = !hold && (qc == QW'(CLK_DIV-1));
    assign slot_end = qend && (q == 2'd3);
    assign sample   = qend && (q == 2'd2);
    assign is_tx    = state inside {S_ADDR, S_REG, S_WDATA, S_RADDR};
    assign last_reg = (ridx == 1'(REG_ADDR_BYTES-1));

    // Next write byte is fetched during the ACK slot preceding its WDATA byte
    assign prefetch = slot_end && (bitn == 4'd7) &&
                      ((state == S_REG && last_reg && !rw_q && left != '0) ||
                       (state == S_WDATA && left > CW'(1)));

    always_comb begin
        sda_nx = 1'b0;
        scl_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                sda_nx = 1'b0;
                scl_nx = 1'b0;
            end
            S_START: begin
                sda_nx = q[1];
                scl_nx = (q == 2'd3);
            end
            S_RSTART: begin
                sda_nx = q[1];
                scl_nx = (q == 2'd0) || (q == 2'd3);
            end
            S_STOP: begin
                sda_nx = (q != 2'd3);
                scl_nx = (q == 2'd0);
            end
            S_ADDR, S_REG, S_WDATA, S_RADDR, S_RDATA: begin
                scl_nx = !q[1];
                if (bitn == 4'd8)
                    sda_nx = (state == S_RDATA) && (left > CW'(1));
                else
                    sda_nx = is_tx && !sh[7];
            end
            default: begin
                sda_nx = 1'b0;
                scl_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state    <= S_IDLE;
            q        <= '0;
            qc       <= '0;
            bitn     <= '0;
            sh       <= '0;
            wbuf     <= '0;
            reg_q    <= '0;
            ridx     <= '0;
            left     <= '0;
            rw_q     <= 1'b0;
            slv_q    <= '0;
            ack_bad  <= 1'b0;
            nack_hit <= 1'b0;
            wr_req   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
        end else begin
            done     <= 1'b0;
            wr_req   <= 1'b0;
            rd_valid <= 1'b0;
            sda_oe   <= sda_nx;
            scl_oe   <= scl_nx;
            if (wr_req)
                wbuf <= wr_data;
            if (state == S_IDLE) begin
                if (start) begin
                    state    <= S_START;
                    q        <= '0;
                    qc       <= '0;
                    bitn     <= '0;
                    rw_q     <= rw;
                    slv_q    <= slv_addr;
                    reg_q    <= reg_addr;
                    left     <= (byte_cnt > CW'(MAX_BURST)) ? CW'(MAX_BURST) : byte_cnt;
                    busy     <= 1'b1;
                    nack     <= 1'b0;
                    nack_hit <= 1'b0;
                    ack_bad  <= 1'b0;
                end
            end else begin
                if (!hold) begin
                    if (qc == QW'(CLK_DIV-1)) begin
                        qc <= '0;
                        q  <= q + 2'd1;
                    end else begin
                        qc <= qc + 1'b1;
                    end
                end
                if (sample) begin
                    if (state == S_RDATA && bitn != 4'd8) begin
                        sh <= {sh[6:0], sda_i};
                        if (bitn == 4'd7) begin
                            rd_data  <= {sh[6:0], sda_i};
                            rd_valid <= 1'b1;
                        end
                    end
                    if (is_tx && bitn == 4'd8) begin
                        ack_bad <= sda_i;
                        if (sda_i)
                            nack_hit <= 1'b1;
                    end
                end
                if (prefetch)
                    wr_req <= 1'b1;
                if (slot_end) begin
                    unique case (state)
                        S_START: begin
                            state <= S_ADDR;
                            sh    <= {slv_q, 1'b0};
                            bitn  <= '0;
                        end
                        S_RSTART: begin
                            state <= S_RADDR;
                            sh    <= {slv_q, 1'b1};
                            bitn  <= '0;
                        end
                        S_STOP: begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            nack  <= nack_hit;
                        end
                        S_ADDR, S_REG, S_WDATA, S_RADDR, S_RDATA: begin
                            if (bitn != 4'd8) begin
                                bitn <= bitn + 4'd1;
                                if (is_tx)
                                    sh <= {sh[6:0], 1'b0};
                            end else begin
                                bitn <= '0;
                                if (is_tx && ack_bad) begin
                                    state <= S_STOP;
                                end else if (state == S_ADDR) begin
                                    state <= S_REG;
                                    sh    <= reg_q[RW-1 -: 8];
                                    reg_q <= reg_q << 8;
                                    ridx  <= '0;
                                end else if (state == S_REG) begin
                                    if (!last_reg) begin
                                        sh    <= reg_q[RW-1 -: 8];
                                        reg_q <= reg_q << 8;
                                        ridx  <= ridx + 1'b1;
                                    end else if (left == '0) begin
                                        state <= S_STOP;
                                    end else if (rw_q) begin
                                        state <= S_RSTART;
                                    end else begin
                                        state <= S_WDATA;
                                        sh    <= wbuf;
                                    end
                                end else if (state == S_WDATA) begin
                                    left <= left - 1'b1;
                                    if (left > CW'(1))
                                        sh <= wbuf;
                                    else
                                        state <= S_STOP;
                                end else if (state == S_RADDR) begin
                                    state <= S_RDATA;
                                end else begin
                                    left <= left - 1'b1;
                                    if (left <= CW'(1))
                                        state <= S_STOP;
                                end
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural I2C slave on a shared open-drain
// bus plus scoreboard queues for bus bytes, read data and transaction ends.
module tb_i2c_master_burst;

    logic       dclk = 1'b0;
    logic       rst;
    logic       start0, start1, rw;
    logic [6:0] slv;
    logic [7:0] reg0;
    logic [15:0] reg1;
    logic [4:0] bcnt;
    logic [7:0] wr_data;

    logic       wr_req0, rd_valid0, busy0, done0, nack0, sda_oe0, scl_oe0;
    logic       wr_req1, rd_valid1, busy1, done1, nack1, sda_oe1, scl_oe1;
    logic [7:0] rd_data0, rd_data1;

    logic slave_low = 1'b0;
    logic stretch = 1'b0;
    logic sda_bus, scl_bus;
    assign sda_bus = ~(sda_oe0 | sda_oe1 | slave_low);
    assign scl_bus = ~(scl_oe0 | scl_oe1 | stretch);

    always #5 dclk = ~dclk;

    i2c_master_burst #(.CLK_DIV(4), .REG_ADDR_BYTES(1), .MAX_BURST(16)) u0 (
        .dclk(dclk), .rst(rst), .start(start0), .rw(rw), .slv_addr(slv),
        .reg_addr(reg0), .byte_cnt(bcnt), .wr_data(wr_data), .wr_req(wr_req0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0), .done(done0),
        .nack(nack0), .sda_i(sda_bus), .sda_oe(sda_oe0), .scl_i(scl_bus),
        .scl_oe(scl_oe0)
    );

    i2c_master_burst #(.CLK_DIV(4), .REG_ADDR_BYTES(2), .MAX_BURST(16)) u1 (
        .dclk(dclk), .rst(rst), .start(start1), .rw(rw), .slv_addr(slv),
        .reg_addr(reg1), .byte_cnt(bcnt), .wr_data(wr_data), .wr_req(wr_req1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .done(done1),
        .nack(nack1), .sda_i(sda_bus), .sda_oe(sda_oe1), .scl_i(scl_bus),
        .scl_oe(scl_oe1)
    );

    typedef struct {
        int busy_len;
        int nack;
        int wreqs;
        int rdvs;
    } done_t;

    int    exp_bus[$];
    int    exp_rd[$];
    int    exp_mack[$];
    int    rdq[$];
    int    wq[$];
    done_t exp_done[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Behavioural slave and stretch generator
    logic       cs, cd, fall, prev_scl = 1'b1, prev_sda = 1'b1;
    logic       ackdone, rmode, rpend, first, mack, drive_next;
    logic       stretch_req = 1'b0;
    logic [7:0] rx, tx;
    int         bc, byte_idx, scnt;
    int         nack_at = -1;

    initial begin
        bc = 0; ackdone = 0; rmode = 0; rpend = 0; first = 0; mack = 1;
        byte_idx = 0; scnt = 0; rx = 0; tx = 0;
        forever begin
            @(negedge dclk);
            cs = scl_bus;
            cd = sda_bus;
            fall = prev_scl && !cs;
            if (rst) begin
                bc = 0; ackdone = 0; rmode = 0; rpend = 0; first = 0;
                byte_idx = 0; slave_low = 1'b0; stretch = 1'b0;
            end else begin
                if (prev_scl && cs && prev_sda && !cd) begin
                    bc = 0; ackdone = 0; rmode = 0; rpend = 0; first = 1;
                    slave_low = 1'b0;
                end else if (prev_scl && cs && !prev_sda && cd) begin
                    bc = 0; ackdone = 0; rmode = 0; rpend = 0; first = 0;
                    byte_idx = 0; slave_low = 1'b0;
                end else if (!prev_scl && cs) begin
                    if (bc < 8) begin
                        rx = {rx[6:0], cd};
                        bc++;
                    end else begin
                        ackdone = 1;
                        if (rmode) begin
                            mack = cd;
                            chk("master_ack", int'(cd),
                                exp_mack.size() ? exp_mack.pop_front() : -1);
                        end
                    end
                end else if (fall) begin
                    if (bc == 8 && !ackdone) begin
                        if (rmode) begin
                            slave_low = 1'b0;
                        end else begin
                            chk("bus_byte", int'(rx),
                                exp_bus.size() ? exp_bus.pop_front() : -1);
                            slave_low = (byte_idx != nack_at);
                            if (first && rx[0])
                                rpend = 1;
                            first = 0;
                            byte_idx++;
                        end
                    end else if (bc == 8) begin
                        bc = 0;
                        ackdone = 0;
                        drive_next = rpend || (rmode && !mack);
                        if (rpend) begin
                            rmode = 1;
                            rpend = 0;
                        end
                        if (drive_next) begin
                            tx = rdq.size() ? 8'(rdq.pop_front()) : 8'hFF;
                            slave_low = !tx[7];
                        end else begin
                            slave_low = 1'b0;
                        end
                    end else if (rmode && bc >= 1 && bc <= 7) begin
                        slave_low = !tx[7-bc];
                    end
                end
                if (stretch_req && !stretch && fall) begin
                    stretch = 1'b1;
                    stretch_req = 1'b0;
                    scnt = 0;
                end else if (stretch) begin
                    if (scnt == 20)
                        stretch = 1'b0;
                    else if (!scl_oe0 && !scl_oe1)
                        scnt++;
                end
            end
            prev_scl = cs;
            prev_sda = cd;
        end
    end

    // Monitor: transaction ends, read data, write-byte supply
    int busy_cnt = 0, wreq_cnt = 0, rdv_cnt = 0;
    done_t d;

    initial begin
        forever begin
            @(negedge dclk);
            if (rst) begin
                busy_cnt = 0; wreq_cnt = 0; rdv_cnt = 0;
            end else begin
                if (busy0 | busy1)
                    busy_cnt++;
                if (wr_req0 | wr_req1) begin
                    wreq_cnt++;
                    wr_data = wq.size() ? 8'(wq.pop_front()) : 8'h00;
                end
                if (rd_valid0 | rd_valid1) begin
                    rdv_cnt++;
                    chk("rd_data", int'(rd_valid0 ? rd_data0 : rd_data1),
                        exp_rd.size() ? exp_rd.pop_front() : -1);
                end
                if (done0 | done1) begin
                    if (exp_done.size()) begin
                        d = exp_done.pop_front();
                    end else begin
                        d.busy_len = -1; d.nack = -1; d.wreqs = -1; d.rdvs = -1;
                    end
                    chk("busy_len", busy_cnt, d.busy_len);
                    chk("nack", int'(done0 ? nack0 : nack1), d.nack);
                    chk("wr_req_cnt", wreq_cnt, d.wreqs);
                    chk("rd_valid_cnt", rdv_cnt, d.rdvs);
                    chk("busy_at_done", int'(busy0 | busy1), 0);
                    busy_cnt = 0; wreq_cnt = 0; rdv_cnt = 0;
                end
            end
        end
    end

    task automatic go(input bit which, input bit r, input logic [6:0] a,
                      input logic [15:0] ra, input logic [4:0] n);
        @(negedge dclk);
        rw = r; slv = a; reg0 = ra[7:0]; reg1 = ra; bcnt = n;
        if (which) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge dclk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit got = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge dclk);
            if (done0 | done1) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", int'(got), 1);
        repeat (4) @(negedge dclk);
    endtask

    function automatic done_t mk(input int b, input int n, input int w, input int r);
        done_t t;
        t.busy_len = b; t.nack = n; t.wreqs = w; t.rdvs = r;
        return t;
    endfunction

    initial begin
        rst = 1'b1; start0 = 0; start1 = 0; rw = 0; slv = 0;
        reg0 = 0; reg1 = 0; bcnt = 0; wr_data = 0;
        repeat (3) @(negedge dclk);
        chk("rst_sda_oe", int'(sda_oe0), 0);
        chk("rst_scl_oe", int'(scl_oe0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_nack", int'(nack0), 0);
        chk("rst_wr_req", int'(wr_req0), 0);
        chk("rst_rd_valid", int'(rd_valid0), 0);
        chk("rst_rd_data", int'(rd_data0), 0);
        rst = 1'b0;
        repeat (3) @(negedge dclk);

        // Write burst of two bytes, with an ignored start while busy
        exp_bus = '{'hA0, 'h10, 'hA5, 'h3C};
        wq = '{'hA5, 'h3C};
        exp_done.push_back(mk(608, 0, 2, 0));
        go(0, 0, 7'h50, 16'h0010, 5'd2);
        repeat (100) @(negedge dclk);
        start0 = 1'b1;
        @(negedge dclk);
        start0 = 1'b0;
        wait_done(2000);

        // Read burst of two bytes
        exp_bus = '{'hA0, 'h10, 'hA1};
        rdq = '{'h12, 'h34};
        exp_rd = '{'h12, 'h34};
        exp_mack = '{0, 1};
        exp_done.push_back(mk(768, 0, 0, 2));
        go(0, 1, 7'h50, 16'h0010, 5'd2);
        wait_done(2000);

        // Slave NACKs the address byte
        nack_at = 0;
        exp_bus = '{'hA0};
        exp_done.push_back(mk(176, 1, 0, 0));
        go(0, 0, 7'h50, 16'h0010, 5'd2);
        wait_done(1000);
        nack_at = -1;
        chk("nack_held", int'(nack0), 1);

        // Two register-address bytes, no data
        exp_bus = '{'hA0, 'h12, 'h34};
        exp_done.push_back(mk(464, 0, 0, 0));
        go(1, 0, 7'h50, 16'h1234, 5'd0);
        wait_done(1000);

        // SCL stretched for 20 dclk during the address byte
        exp_bus = '{'h54, 'h7E, 'hC3};
        wq = '{'hC3};
        exp_done.push_back(mk(484, 0, 1, 0));
        stretch_req = 1'b1;
        go(0, 0, 7'h2A, 16'h007E, 5'd1);
        chk("nack_cleared", int'(nack0), 0);
        wait_done(1000);

        // Read with zero bytes: no repeated START
        exp_bus = '{'hA0, 'h10};
        exp_done.push_back(mk(320, 0, 0, 0));
        go(0, 1, 7'h50, 16'h0010, 5'd0);
        wait_done(1000);

        // Oversized byte count is clamped to sixteen
        exp_bus = '{'hA0, 'h10};
        wq.delete();
        for (int i = 0; i < 16; i++) begin
            exp_bus.push_back((i * 17 + 1) & 'hFF);
            wq.push_back((i * 17 + 1) & 'hFF);
        end
        exp_done.push_back(mk(2624, 0, 16, 0));
        go(0, 0, 7'h50, 16'h0010, 5'd31);
        wait_done(4000);

        // Reset in the middle of the register byte
        exp_bus = '{'hA0};
        go(0, 0, 7'h50, 16'h0010, 5'd2);
        repeat (200) @(negedge dclk);
        rst = 1'b1;
        @(posedge dclk);
        #1;
        chk("midrst_sda_oe", int'(sda_oe0), 0);
        chk("midrst_scl_oe", int'(scl_oe0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        @(negedge dclk);
        rst = 1'b0;
        chk("midrst_addr_seen", exp_bus.size(), 0);
        exp_bus.delete();
        repeat (4) @(negedge dclk);

        // Fresh transaction after the reset
        exp_bus = '{'hA0, 'h10, 'h5A};
        wq = '{'h5A};
        exp_done.push_back(mk(464, 0, 1, 0));
        go(0, 0, 7'h50, 16'h0010, 5'd1);
        wait_done(1000);

        chk("left_bus", exp_bus.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("left_mack", exp_mack.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
